id_exe_stage: RTL and testbench
===============================

ID_EXE_STAGE -- requirements
Module: id_exe_stage

Interface
REQ-001 Parameter DW, default 32, datapath width of operands, immediates and forwarded results.
REQ-002 Parameter CNT_W, default 16, width of the load-use stall counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ID_valid  in  1  instruction in ID is real (not a bubble).
REQ-006 ID_A, ID_B  in  DW each  register-file read data for rs1 and rs2/rd-as-store-source.
REQ-007 ID_imm  in  DW  sign-extended immediate.
REQ-008 ID_ALUSRC  in  1  1 = operand B is ID_imm, 0 = register.
REQ-009 ID_ALUC  in  4  ALU opcode.
REQ-010 ID_rd  in  5  destination register.
REQ-011 ID_WREG, ID_SLD, ID_WMEM  in  1 each  reg write, load, store.
REQ-012 A_DEPEN, B_DEPEN  in  2 each  from hazard unit; bit0 = EXE-stage match, bit1 = MEM-stage match.
REQ-013 LOAD_DEPEN  in  1  from hazard unit; ID source depends on a load now in EXE.
REQ-014 FLUSH  in  1  taken branch/jump resolved; kill instruction in ID.
REQ-015 EXE_ALU, MEM_DATA  in  DW each  EXE-stage ALU result; MEM-stage result (load data for loads).
REQ-016 EXE_A, EXE_B, EXE_ST  out  DW each  registered ALU operands and store data.
REQ-017 EXE_ALUC  out  4; EXE_rd  out  5; EXE_WREG, EXE_SLD, EXE_WMEM, EXE_valid  out  1 each  registered controls.
REQ-018 PC_WRITE, IFID_WRITE  out  1 each  combinational enables for PC and IF/ID register.
REQ-019 STALL_CNT  out  CNT_W  count of load-use stall cycles.

Function
REQ-020 Forwarded A SHALL be EXE_ALU if A_DEPEN[0], else MEM_DATA if A_DEPEN[1], else ID_A (EXE wins when both bits set).
REQ-021 Forwarded B SHALL use the same priority over ID_B with B_DEPEN.
REQ-022 EXE_B SHALL capture ID_imm when ID_ALUSRC=1, else forwarded B; EXE_ST SHALL always capture forwarded B.
REQ-023 Normal cycle (ID_valid=1, LOAD_DEPEN=0, FLUSH=0): all EXE_* registers capture ID values next edge; latency 1 cycle; EXE_valid=1.
REQ-024 Bubble cycle: when FLUSH=1, or LOAD_DEPEN=1 with ID_valid=1, or ID_valid=0, EXE_* SHALL load zero (valid, WREG, SLD, WMEM, rd, ALUC, operands all 0).
REQ-025 A_DEPEN/B_DEPEN SHALL be ignored when ID_valid=0.
REQ-026 PC_WRITE = IFID_WRITE = NOT(LOAD_DEPEN AND ID_valid AND NOT FLUSH); FLUSH overrides a load-use stall.
REQ-027 A load-use stall SHALL last exactly one cycle: the bubble clears EXE_SLD, and the retried instruction forwards from MEM_DATA via A_DEPEN[1]/B_DEPEN[1].
REQ-028 STALL_CNT SHALL increment by 1 on each edge where PC_WRITE=0, saturating at all-ones (no wrap).
REQ-029 Flush cycles SHALL NOT increment STALL_CNT.

Reset
REQ-030 rst_n=0 at an edge SHALL clear all EXE_* outputs and STALL_CNT to 0, overriding any concurrent capture or stall.
REQ-031 PC_WRITE/IFID_WRITE stay combinational; the zeroed EXE_SLD after reset SHALL prevent spurious stalls from this block's own state.
REQ-032 Reset asserted mid-stall SHALL discard the stall; first edge after release behaves per REQ-023/024.

Verification
REQ-033 Pass-through: ID_A=0x11, ID_B=0x22, ALUSRC=0, WREG=1, rd=5, no deps -> next cycle EXE_A=0x11, EXE_B=0x22, EXE_ST=0x22, EXE_rd=5, EXE_valid=1.
REQ-034 Forward priority: A_DEPEN=2'b11, EXE_ALU=0xAA, MEM_DATA=0xBB -> EXE_A=0xAA; A_DEPEN=2'b10 -> EXE_A=0xBB; ALUSRC=1, imm=0x7, B_DEPEN=2'b01 -> EXE_B=0x7, EXE_ST=0xAA.
REQ-035 Load-use: ID_valid=1, LOAD_DEPEN=1 for one cycle -> PC_WRITE=IFID_WRITE=0 that cycle, next cycle EXE_valid=0, EXE_WREG=0, STALL_CNT=1; retry with A_DEPEN=2'b10 captures MEM_DATA.
REQ-036 Flush vs stall: FLUSH=1 and LOAD_DEPEN=1 same cycle -> PC_WRITE=1, bubble in EXE, STALL_CNT unchanged.
REQ-037 Saturation: CNT_W=4, 17 stall cycles -> STALL_CNT=15 and holds.
REQ-038 Reset mid-operation: rst_n=0 during stall with EXE_WREG=1 -> next edge all EXE_* = 0, STALL_CNT=0.

Source files
------------

// File: rtl/id_exe_stage_if.sv
// ID/EXE pipeline boundary bundle: decoded instruction, hazard-unit flags,
// forwarding sources, registered EXE-side outputs and fetch enables.
// master = decode/hazard side driving ID_*, slave = the id_exe_stage register.
interface id_exe_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  // Decode side
  logic             ID_valid;
  logic [DW-1:0]    ID_A;
  logic [DW-1:0]    ID_B;
  logic [DW-1:0]    ID_imm;
  logic             ID_ALUSRC;
  logic [3:0]       ID_ALUC;
  logic [4:0]       ID_rd;
  logic             ID_WREG;
  logic             ID_SLD;
  logic             ID_WMEM;
  // Hazard unit
  logic [1:0]       A_DEPEN;
  logic [1:0]       B_DEPEN;
  logic             LOAD_DEPEN;
  logic             FLUSH;
  // Forwarding sources from later stages
  logic [DW-1:0]    EXE_ALU;
  logic [DW-1:0]    MEM_DATA;
  // Registered EXE-stage view
  logic [DW-1:0]    EXE_A;
  logic [DW-1:0]    EXE_B;
  logic [DW-1:0]    EXE_ST;
  logic [3:0]       EXE_ALUC;
  logic [4:0]       EXE_rd;
  logic             EXE_WREG;
  logic             EXE_SLD;
  logic             EXE_WMEM;
  logic             EXE_valid;
  // Fetch enables and stall statistics
  logic             PC_WRITE;
  logic             IFID_WRITE;
  logic [CNT_W-1:0] STALL_CNT;

  modport master (
    output ID_valid, ID_A, ID_B, ID_imm, ID_ALUSRC, ID_ALUC, ID_rd,
           ID_WREG, ID_SLD, ID_WMEM, A_DEPEN, B_DEPEN, LOAD_DEPEN, FLUSH,
           EXE_ALU, MEM_DATA,
    input  EXE_A, EXE_B, EXE_ST, EXE_ALUC, EXE_rd, EXE_WREG, EXE_SLD,
           EXE_WMEM, EXE_valid, PC_WRITE, IFID_WRITE, STALL_CNT
  );

  modport slave (
    input  ID_valid, ID_A, ID_B, ID_imm, ID_ALUSRC, ID_ALUC, ID_rd,
           ID_WREG, ID_SLD, ID_WMEM, A_DEPEN, B_DEPEN, LOAD_DEPEN, FLUSH,
           EXE_ALU, MEM_DATA,
    output EXE_A, EXE_B, EXE_ST, EXE_ALUC, EXE_rd, EXE_WREG, EXE_SLD,
           EXE_WMEM, EXE_valid, PC_WRITE, IFID_WRITE, STALL_CNT
  );
endinterface

// File: rtl/id_exe_stage.sv
// ID->EXE pipeline register with operand forwarding, bubble insertion and a load-use stall counter.
// Latency: 1 cycle from ID inputs to EXE_* outputs; PC_WRITE/IFID_WRITE are combinational.
// Backpressure: a load-use hazard deasserts PC_WRITE/IFID_WRITE for one cycle and injects a bubble; FLUSH overrides.
//
// Ports: clk, rst_n (synchronous, active-low); bus (id_exe_if.slave) carries
// the ID-side instruction, hazard flags, forwarding sources, the registered
// EXE_* bundle, the fetch enables and STALL_CNT.
module id_exe_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  id_exe_if.slave bus
);

  logic          stall;
  logic          capture;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  logic [CNT_W-1:0] cnt_q;

  // Hold fetch only for a live load-use hazard; a flush kills the dependent
  // instruction anyway, so stalling for it would waste a cycle.
  assign stall   = bus.LOAD_DEPEN & bus.ID_valid & ~bus.FLUSH;
  assign capture = bus.ID_valid & ~bus.LOAD_DEPEN & ~bus.FLUSH;

  assign bus.PC_WRITE   = ~stall;
  assign bus.IFID_WRITE = ~stall;
  assign bus.STALL_CNT  = cnt_q;

  // Youngest producer (EXE) wins over MEM. Dependency flags on a bubble are
  // meaningless and are ignored.
  always_comb begin
    fwd_a = bus.ID_A;
    if (bus.ID_valid) begin
      if (bus.A_DEPEN[0])      fwd_a = bus.EXE_ALU;
      else if (bus.A_DEPEN[1]) fwd_a = bus.MEM_DATA;
    end
  end

  always_comb begin
    fwd_b = bus.ID_B;
    if (bus.ID_valid) begin
      if (bus.B_DEPEN[0])      fwd_b = bus.EXE_ALU;
      else if (bus.B_DEPEN[1]) fwd_b = bus.MEM_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !capture) begin
      // Bubble: every EXE field zeroed so EXE_SLD=0 cannot re-trigger a stall.
      bus.EXE_A     <= '0;
      bus.EXE_B     <= '0;
      bus.EXE_ST    <= '0;
      bus.EXE_ALUC  <= '0;
      bus.EXE_rd    <= '0;
      bus.EXE_WREG  <= 1'b0;
      bus.EXE_SLD   <= 1'b0;
      bus.EXE_WMEM  <= 1'b0;
      bus.EXE_valid <= 1'b0;
    end else begin
      bus.EXE_A     <= fwd_a;
      bus.EXE_B     <= bus.ID_ALUSRC ? bus.ID_imm : fwd_b;
      bus.EXE_ST    <= fwd_b;
      bus.EXE_ALUC  <= bus.ID_ALUC;
      bus.EXE_rd    <= bus.ID_rd;
      bus.EXE_WREG  <= bus.ID_WREG;
      bus.EXE_SLD   <= bus.ID_SLD;
      bus.EXE_WMEM  <= bus.ID_WMEM;
      bus.EXE_valid <= 1'b1;
    end
  end

  // Saturating stall counter; flush cycles never reach here since stall=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_exe_stage.sv
module tb_id_exe_stage;

  typedef struct packed {
    logic        v, w, s, m;
    logic [4:0]  rd;
    logic [3:0]  aluc;
    logic [31:0] a, b, st;
    logic [15:0] cnt;
    logic [3:0]  sat;
  } exe_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_exe_if #(.DW(32), .CNT_W(16)) bus ();
  id_exe_if #(.DW(32), .CNT_W(4))  sbus ();

  id_exe_stage #(.DW(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  id_exe_stage #(.DW(32), .CNT_W(4))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

  // Second instance sees identical stimulus; only its counter width differs.
  assign sbus.ID_valid   = bus.ID_valid;
  assign sbus.ID_A       = bus.ID_A;
  assign sbus.ID_B       = bus.ID_B;
  assign sbus.ID_imm     = bus.ID_imm;
  assign sbus.ID_ALUSRC  = bus.ID_ALUSRC;
  assign sbus.ID_ALUC    = bus.ID_ALUC;
  assign sbus.ID_rd      = bus.ID_rd;
  assign sbus.ID_WREG    = bus.ID_WREG;
  assign sbus.ID_SLD     = bus.ID_SLD;
  assign sbus.ID_WMEM    = bus.ID_WMEM;
  assign sbus.A_DEPEN    = bus.A_DEPEN;
  assign sbus.B_DEPEN    = bus.B_DEPEN;
  assign sbus.LOAD_DEPEN = bus.LOAD_DEPEN;
  assign sbus.FLUSH      = bus.FLUSH;
  assign sbus.EXE_ALU    = bus.EXE_ALU;
  assign sbus.MEM_DATA   = bus.MEM_DATA;

  int errors = 0;
  int checks = 0;
  exe_t exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic [3:0]  exp_sat = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] dep, input logic [31:0] id_v,
                                      input logic [31:0] alu, input logic [31:0] mem);
    case (dep)
      2'b01, 2'b11: return alu;
      2'b10:        return mem;
      default:      return id_v;
    endcase
  endfunction

  task automatic set_ins(input logic vld, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic alusrc, input logic [3:0] aluc,
                         input logic [4:0] rd, input logic wreg, input logic sld,
                         input logic wmem, input logic [1:0] adep, input logic [1:0] bdep,
                         input logic ld, input logic fl, input logic [31:0] alu,
                         input logic [31:0] mem);
    bus.ID_valid = vld;  bus.ID_A = a;  bus.ID_B = b;  bus.ID_imm = imm;
    bus.ID_ALUSRC = alusrc;  bus.ID_ALUC = aluc;  bus.ID_rd = rd;
    bus.ID_WREG = wreg;  bus.ID_SLD = sld;  bus.ID_WMEM = wmem;
    bus.A_DEPEN = adep;  bus.B_DEPEN = bdep;  bus.LOAD_DEPEN = ld;  bus.FLUSH = fl;
    bus.EXE_ALU = alu;  bus.MEM_DATA = mem;
  endtask

  // One clock: check the fetch enables, push the model's prediction,
  // advance, then pop and compare against the registered outputs.
  task automatic step();
    exe_t e;
    logic stall;
    logic [31:0] bf;
    #1;
    stall = bus.LOAD_DEPEN & bus.ID_valid & ~bus.FLUSH;
    chk("pc_write", {31'd0, bus.PC_WRITE}, {31'd0, ~stall});
    chk("ifid_write", {31'd0, bus.IFID_WRITE}, {31'd0, ~stall});
    e = '0;
    if (rst_n && bus.ID_valid && !bus.LOAD_DEPEN && !bus.FLUSH) begin
      bf     = fwd(bus.B_DEPEN, bus.ID_B, bus.EXE_ALU, bus.MEM_DATA);
      e.v    = 1'b1;
      e.w    = bus.ID_WREG;
      e.s    = bus.ID_SLD;
      e.m    = bus.ID_WMEM;
      e.rd   = bus.ID_rd;
      e.aluc = bus.ID_ALUC;
      e.a    = fwd(bus.A_DEPEN, bus.ID_A, bus.EXE_ALU, bus.MEM_DATA);
      e.b    = bus.ID_ALUSRC ? bus.ID_imm : bf;
      e.st   = bf;
    end
    if (!rst_n) begin
      exp_cnt = '0;
      exp_sat = '0;
    end else if (stall) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (exp_sat != 4'hF)     exp_sat = exp_sat + 4'd1;
    end
    e.cnt = exp_cnt;
    e.sat = exp_sat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("exe_valid", {31'd0, bus.EXE_valid}, {31'd0, e.v});
    chk("exe_wreg",  {31'd0, bus.EXE_WREG},  {31'd0, e.w});
    chk("exe_sld",   {31'd0, bus.EXE_SLD},   {31'd0, e.s});
    chk("exe_wmem",  {31'd0, bus.EXE_WMEM},  {31'd0, e.m});
    chk("exe_rd",    {27'd0, bus.EXE_rd},    {27'd0, e.rd});
    chk("exe_aluc",  {28'd0, bus.EXE_ALUC},  {28'd0, e.aluc});
    chk("exe_a",     bus.EXE_A,  e.a);
    chk("exe_b",     bus.EXE_B,  e.b);
    chk("exe_st",    bus.EXE_ST, e.st);
    chk("stall_cnt", {16'd0, bus.STALL_CNT}, {16'd0, e.cnt});
    chk("stall_cnt_sat", {28'd0, sbus.STALL_CNT}, {28'd0, e.sat});
  endtask

  initial begin
    rst_n = 1'b0;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    // Reset state
    step();
    step();
    rst_n = 1'b1;

    // Plain pass-through
    set_ins(1, 32'h11, 32'h22, 32'h0, 0, 4'h3, 5'd5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 32'hAA, 32'hBB);
    step();
    // Forward priority: both bits set -> EXE
    set_ins(1, 32'h11, 32'h22, 32'h0, 0, 4'h1, 5'd6, 1, 0, 0, 2'b11, 2'b00, 0, 0, 32'hAA, 32'hBB);
    step();
    // MEM-only forward
    set_ins(1, 32'h11, 32'h22, 32'h0, 0, 4'h1, 5'd6, 1, 0, 0, 2'b10, 2'b00, 0, 0, 32'hAA, 32'hBB);
    step();
    // Immediate on B, store data still forwarded from EXE
    set_ins(1, 32'h11, 32'h22, 32'h7, 1, 4'h2, 5'd7, 0, 0, 1, 2'b00, 2'b01, 0, 0, 32'hAA, 32'hBB);
    step();
    // Bubble on ID_valid=0 with stray dependency flags
    set_ins(0, 32'h33, 32'h44, 32'h9, 0, 4'h5, 5'd9, 1, 1, 1, 2'b11, 2'b11, 0, 0, 32'hAA, 32'hBB);
    step();
    // Load instruction, then a dependent one stalls for a cycle, then retries
    set_ins(1, 32'h100, 32'h0, 32'h4, 1, 4'h0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, 0, 32'hAA, 32'hBB);
    step();
    set_ins(1, 32'h55, 32'h66, 32'h0, 0, 4'h4, 5'd9, 1, 0, 0, 2'b01, 2'b00, 1, 0, 32'hAA, 32'hBB);
    step();
    set_ins(1, 32'h55, 32'h66, 32'h0, 0, 4'h4, 5'd9, 1, 0, 0, 2'b10, 2'b00, 0, 0, 32'h0, 32'hCAFE);
    step();
    // Flush wins over load-use
    set_ins(1, 32'h77, 32'h88, 32'h0, 0, 4'h6, 5'd10, 1, 0, 0, 2'b00, 2'b00, 1, 1, 32'hAA, 32'hBB);
    step();
    // Plain flush
    set_ins(1, 32'h77, 32'h88, 32'h0, 0, 4'h6, 5'd10, 1, 0, 0, 2'b00, 2'b00, 0, 1, 32'hAA, 32'hBB);
    step();

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      set_ins(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
              1'($urandom), 4'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom), 2'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
              $urandom, $urandom);
      step();
    end

    // Saturation of the narrow counter
    for (int i = 0; i < 17; i++) begin
      set_ins(1, 32'h1, 32'h2, 32'h0, 0, 4'h0, 5'd1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 32'h0, 32'h0);
      step();
    end
    chk("sat_hold", {28'd0, sbus.STALL_CNT}, 32'd15);

    // Reset asserted during a stall with EXE_WREG=1 live
    set_ins(1, 32'h12, 32'h34, 32'h0, 0, 4'h9, 5'd12, 1, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    step();
    set_ins(1, 32'h12, 32'h34, 32'h0, 0, 4'h9, 5'd12, 1, 0, 0, 2'b00, 2'b00, 1, 0, 32'h0, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_ins(1, 32'h56, 32'h78, 32'h0, 0, 4'hA, 5'd13, 1, 0, 1, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
